// File: rtl/hamming_pkg.sv
// Shared types and helpers for the SECDED error-locator datapath.
package hamming_pkg;

  // Per-lane outcome of the SECDED decode.
  typedef enum logic [1:0] {
    ST_CLEAN = 2'd0,
    ST_CORR  = 2'd1,
    ST_PAR   = 2'd2,
    ST_UE    = 2'd3
  } secded_status_t;

  // Upper bound on lanes supported by the lane-count helper.
  localparam int MAX_LANES  = 32;
  localparam int LANE_CNT_W = 6;

  // Number of lanes flagged in a per-lane hit vector (0..MAX_LANES).
  function automatic logic [LANE_CNT_W-1:0] popcount_lanes(input logic [MAX_LANES-1:0] i_hits);
    logic [LANE_CNT_W-1:0] v_n;
    v_n = {LANE_CNT_W{1'b0}};
    for (int i = 0; i < MAX_LANES; i++) begin
      v_n = v_n + {{(LANE_CNT_W-1){1'b0}}, i_hits[i]};
    end
    return v_n;
  endfunction

endpackage

// File: rtl/secded_lane_decode.sv
// Combinational SECDED locator for one lane: syndrome + overall parity
// flag + precomputed range check -> one-hot correction mask and status.
module secded_lane_decode
  import hamming_pkg::*;
#(
  parameter int SYN_WIDTH  = 7,
  parameter int CODE_WIDTH = 127
) (
  input  logic [SYN_WIDTH-1:0]  i_syndrome,
  input  logic                  i_parity_err,
  input  logic                  i_range_ok,
  output logic [CODE_WIDTH-1:0] o_mask,
  output secded_status_t        o_status
);

  secded_status_t w_status;

  // Classify the lane from syndrome, parity flag and range check.
  always_comb begin
    w_status = ST_CLEAN;
    if (i_syndrome == {SYN_WIDTH{1'b0}}) begin
      if (i_parity_err) begin
        w_status = ST_PAR;
      end else begin
        w_status = ST_CLEAN;
      end
    end else if (i_parity_err && i_range_ok) begin
      w_status = ST_CORR;
    end else begin
      w_status = ST_UE;
    end
  end

  // Mask bit i marks codeword position i+1; at most one bit can match.
  always_comb begin
    o_mask = {CODE_WIDTH{1'b0}};
    for (int i = 0; i < CODE_WIDTH; i++) begin
      o_mask[i] = (w_status == ST_CORR) && (i_syndrome == SYN_WIDTH'(i + 1));
    end
  end

  assign o_status = w_status;

endmodule

// File: rtl/secded_locator_pipe.sv
// Two-stage pipelined multi-lane SECDED error locator with valid/ready
// handshake and saturating corrected / uncorrectable event counters.
module secded_locator_pipe
  import hamming_pkg::*;
#(
  parameter int SYN_WIDTH  = 7,
  parameter int CODE_WIDTH = 127,
  parameter int LANES      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*SYN_WIDTH-1:0]  in_syndrome,
  input  logic [LANES-1:0]            in_parity_err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*CODE_WIDTH-1:0] out_mask,
  output logic [LANES*2-1:0]          out_status,
  input  logic                        cnt_clear,
  output logic [CNT_WIDTH-1:0]        corr_count,
  output logic [CNT_WIDTH-1:0]        ue_count
);

  localparam logic [SYN_WIDTH-1:0] CODE_LIMIT = SYN_WIDTH'(CODE_WIDTH);
  localparam int                   SUM_W      = CNT_WIDTH + LANE_CNT_W + 1;
  localparam logic [SUM_W-1:0]     CNT_MAX    = SUM_W'({CNT_WIDTH{1'b1}});

  logic                        r_s1_valid;
  logic [LANES*SYN_WIDTH-1:0]  r_s1_syn;
  logic [LANES-1:0]            r_s1_par;
  logic [LANES-1:0]            r_s1_rok;
  logic                        r_s2_valid;
  logic [LANES*CODE_WIDTH-1:0] r_s2_mask;
  logic [LANES*2-1:0]          r_s2_status;
  logic [CNT_WIDTH-1:0]        r_corr_cnt;
  logic [CNT_WIDTH-1:0]        r_ue_cnt;

  logic                        w_adv1;
  logic                        w_adv2;
  logic                        w_in_fire;
  logic                        w_out_fire;
  logic [LANES-1:0]            w_in_rok;
  logic [LANES*CODE_WIDTH-1:0] w_dec_mask;
  logic [LANES*2-1:0]          w_dec_status;
  logic [MAX_LANES-1:0]        w_corr_hits;
  logic [MAX_LANES-1:0]        w_ue_hits;
  logic [SUM_W-1:0]            w_corr_sum;
  logic [SUM_W-1:0]            w_ue_sum;
  logic [CNT_WIDTH-1:0]        w_corr_next;
  logic [CNT_WIDTH-1:0]        w_ue_next;

  // S2 drains when empty or accepted; S1 moves whenever S2 can take it,
  // so no bubble is inserted. in_ready never depends on in_valid.
  assign w_adv2     = ~r_s2_valid | out_ready;
  assign w_adv1     = ~r_s1_valid | w_adv2;
  assign in_ready   = w_adv1;
  assign w_in_fire  = in_valid & w_adv1;
  assign w_out_fire = r_s2_valid & out_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    secded_status_t w_lane_status;

    assign w_in_rok[k] = (in_syndrome[k*SYN_WIDTH +: SYN_WIDTH] <= CODE_LIMIT);

    secded_lane_decode #(
      .SYN_WIDTH  (SYN_WIDTH),
      .CODE_WIDTH (CODE_WIDTH)
    ) u_dec (
      .i_syndrome   (r_s1_syn[k*SYN_WIDTH +: SYN_WIDTH]),
      .i_parity_err (r_s1_par[k]),
      .i_range_ok   (r_s1_rok[k]),
      .o_mask       (w_dec_mask[k*CODE_WIDTH +: CODE_WIDTH]),
      .o_status     (w_lane_status)
    );

    assign w_dec_status[k*2 +: 2] = w_lane_status;
  end

  // Stage 1: capture syndrome, parity flag and range check on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_syn   <= {(LANES*SYN_WIDTH){1'b0}};
      r_s1_par   <= {LANES{1'b0}};
      r_s1_rok   <= {LANES{1'b0}};
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_syn <= in_syndrome;
        r_s1_par <= in_parity_err;
        r_s1_rok <= w_in_rok;
      end else begin
        r_s1_syn <= r_s1_syn;
        r_s1_par <= r_s1_par;
        r_s1_rok <= r_s1_rok;
      end
    end else begin
      r_s1_valid <= r_s1_valid;
    end
  end

  // Stage 2: capture decoded mask/status; holds while stalled downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_mask   <= {(LANES*CODE_WIDTH){1'b0}};
      r_s2_status <= {(LANES*2){1'b0}};
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mask   <= w_dec_mask;
        r_s2_status <= w_dec_status;
      end else begin
        r_s2_mask   <= r_s2_mask;
        r_s2_status <= r_s2_status;
      end
    end else begin
      r_s2_valid <= r_s2_valid;
    end
  end

  // Flag which output lanes carry correctable or uncorrectable events.
  always_comb begin
    w_corr_hits = {MAX_LANES{1'b0}};
    w_ue_hits   = {MAX_LANES{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      w_corr_hits[k] = (secded_status_t'(r_s2_status[k*2 +: 2]) == ST_CORR) ||
                       (secded_status_t'(r_s2_status[k*2 +: 2]) == ST_PAR);
      w_ue_hits[k]   = (secded_status_t'(r_s2_status[k*2 +: 2]) == ST_UE);
    end
  end

  // Saturating next values for both counters (wide sum, then clamp).
  always_comb begin
    w_corr_sum = SUM_W'(r_corr_cnt) + SUM_W'(popcount_lanes(w_corr_hits));
    w_ue_sum   = SUM_W'(r_ue_cnt) + SUM_W'(popcount_lanes(w_ue_hits));
    if (w_corr_sum > CNT_MAX) begin
      w_corr_next = {CNT_WIDTH{1'b1}};
    end else begin
      w_corr_next = w_corr_sum[CNT_WIDTH-1:0];
    end
    if (w_ue_sum > CNT_MAX) begin
      w_ue_next = {CNT_WIDTH{1'b1}};
    end else begin
      w_ue_next = w_ue_sum[CNT_WIDTH-1:0];
    end
  end

  // Event counters advance on output transfer; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_corr_cnt <= {CNT_WIDTH{1'b0}};
      r_ue_cnt   <= {CNT_WIDTH{1'b0}};
    end else if (cnt_clear) begin
      r_corr_cnt <= {CNT_WIDTH{1'b0}};
      r_ue_cnt   <= {CNT_WIDTH{1'b0}};
    end else if (w_out_fire) begin
      r_corr_cnt <= w_corr_next;
      r_ue_cnt   <= w_ue_next;
    end else begin
      r_corr_cnt <= r_corr_cnt;
      r_ue_cnt   <= r_ue_cnt;
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_mask   = r_s2_mask;
  assign out_status = r_s2_status;
  assign corr_count = r_corr_cnt;
  assign ue_count   = r_ue_cnt;

endmodule

// File: tb/tb_secded_locator_pipe.sv
// Scoreboard bench for secded_locator_pipe with a narrowed code width
// (72) and 4-bit counters so range and saturation corners are reachable.
module tb_secded_locator_pipe;

  localparam int SYN_W  = 7;
  localparam int CODE_W = 72;
  localparam int LANES  = 2;
  localparam int CNT_W  = 4;

  typedef struct {
    logic [LANES*CODE_W-1:0] mask;
    logic [LANES*2-1:0]      status;
    logic [1:0]              corr_n;
    logic [1:0]              ue_n;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*SYN_W-1:0]  in_syndrome;
  logic [LANES-1:0]        in_parity_err;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*CODE_W-1:0] out_mask;
  logic [LANES*2-1:0]      out_status;
  logic                    cnt_clear;
  logic [CNT_W-1:0]        corr_count;
  logic [CNT_W-1:0]        ue_count;

  exp_t                    sb[$];
  int                      n_checks = 0;
  int                      n_errors = 0;
  int                      ir_low_seen = 0;
  logic [CNT_W-1:0]        m_corr = 4'd0;
  logic [CNT_W-1:0]        m_ue = 4'd0;
  logic                    prev_stall = 1'b0;
  logic [LANES*CODE_W-1:0] prev_mask = '0;
  logic [LANES*2-1:0]      prev_status = '0;

  secded_locator_pipe #(
    .SYN_WIDTH  (SYN_W),
    .CODE_WIDTH (CODE_W),
    .LANES      (LANES),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_syndrome   (in_syndrome),
    .in_parity_err (in_parity_err),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mask      (out_mask),
    .out_status    (out_status),
    .cnt_clear     (cnt_clear),
    .corr_count    (corr_count),
    .ue_count      (ue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    int s;
    s = int'(a) + int'(b);
    return (s > 15) ? 4'd15 : CNT_W'(s);
  endfunction

  function automatic void model_lane(input logic [SYN_W-1:0] s, input logic p,
                                     output logic [CODE_W-1:0] m, output logic [1:0] st);
    m = '0;
    if (s == 7'd0)        st = p ? 2'd2 : 2'd0;
    else if (!p)          st = 2'd3;
    else if (s > 7'd72)   st = 2'd3;
    else begin
      st = 2'd1;
      m[s - 7'd1] = 1'b1;
    end
  endfunction

  function automatic exp_t model_beat(input logic [SYN_W-1:0] s0, input logic p0,
                                      input logic [SYN_W-1:0] s1, input logic p1);
    exp_t e;
    logic [CODE_W-1:0] m0, m1;
    logic [1:0] st0, st1;
    model_lane(s0, p0, m0, st0);
    model_lane(s1, p1, m1, st1);
    e.mask   = {m1, m0};
    e.status = {st1, st0};
    e.corr_n = 2'(int'(st0 == 2'd1 || st0 == 2'd2) + int'(st1 == 2'd1 || st1 == 2'd2));
    e.ue_n   = 2'(int'(st0 == 2'd3) + int'(st1 == 2'd3));
    return e;
  endfunction

  // Hold a beat on the input until accepted, then record its expectation.
  task automatic send_beat(input logic [SYN_W-1:0] s0, input logic p0,
                           input logic [SYN_W-1:0] s1, input logic p1);
    exp_t e;
    logic acc;
    int   waited;
    e             = model_beat(s0, p0, s1, p1);
    in_valid      = 1'b1;
    in_syndrome   = {s1, s0};
    in_parity_err = {p1, p0};
    acc           = 1'b0;
    waited        = 0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (acc) sb.push_back(e);
    else     chk("accept_timeout", 256'(0), 256'(1));
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    in_syndrome   = '0;
    in_parity_err = '0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (sb.size() != 0) chk("drain_timeout", 256'(0), 256'(1));
  endtask

  // Output monitor: handshake, hold-while-stalled, in-order data, counters.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      m_corr     = 4'd0;
      m_ue       = 4'd0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 256'(in_ready), 256'((sb.size() < 2) || out_ready));
      chk("corr_count", 256'(corr_count), 256'(m_corr));
      chk("ue_count", 256'(ue_count), 256'(m_ue));
      if (sb.size() == 0) chk("idle_valid", 256'(out_valid), 256'(0));
      if (prev_stall) begin
        chk("hold_valid", 256'(out_valid), 256'(1));
        chk("hold_mask", 256'(out_mask), 256'(prev_mask));
        chk("hold_status", 256'(out_status), 256'(prev_status));
      end
      if (!in_ready) ir_low_seen++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 256'(1), 256'(0));
        end else begin
          e = sb.pop_front();
          chk("out_mask", 256'(out_mask), 256'(e.mask));
          chk("out_status", 256'(out_status), 256'(e.status));
          if (cnt_clear) begin
            m_corr = 4'd0;
            m_ue   = 4'd0;
          end else begin
            m_corr = sat_add(m_corr, e.corr_n);
            m_ue   = sat_add(m_ue, e.ue_n);
          end
        end
      end else if (cnt_clear) begin
        m_corr = 4'd0;
        m_ue   = 4'd0;
      end
      prev_stall  = out_valid && !out_ready;
      prev_mask   = out_mask;
      prev_status = out_status;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [LANES*CODE_W-1:0] xm;
    int ir_base;
    rst_n = 1'b0;
    out_ready = 1'b1;
    cnt_clear = 1'b0;
    idle();
    #3;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_mask", 256'(out_mask), 256'(0));
    chk("rst_out_status", 256'(out_status), 256'(0));
    chk("rst_corr", 256'(corr_count), 256'(0));
    chk("rst_ue", 256'(ue_count), 256'(0));
    #9;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    @(posedge clk);
    #1;

    // Single CORR beat: two-cycle latency and one-hot mask at bit 4.
    send_beat(7'd5, 1'b1, 7'd0, 1'b0);
    idle();
    chk("t1_lat1_valid", 256'(out_valid), 256'(0));
    @(posedge clk);
    #1;
    chk("t1_lat2_valid", 256'(out_valid), 256'(1));
    xm = '0;
    xm[4] = 1'b1;
    chk("t1_mask", 256'(out_mask), 256'(xm));
    chk("t1_status", 256'(out_status), 256'(4'b0001));
    drain();
    chk("t1_corr", 256'(corr_count), 256'(1));
    chk("t1_ue", 256'(ue_count), 256'(0));

    // PAR in lane 0, double error in lane 1.
    send_beat(7'd0, 1'b1, 7'd3, 1'b0);
    idle();
    drain();
    chk("t2_corr", 256'(corr_count), 256'(2));
    chk("t2_ue", 256'(ue_count), 256'(1));

    // Out-of-range location then the last valid position.
    send_beat(7'd100, 1'b1, 7'd0, 1'b0);
    send_beat(7'd72, 1'b1, 7'd0, 1'b0);
    idle();
    drain();
    chk("t3_corr", 256'(corr_count), 256'(3));
    chk("t3_ue", 256'(ue_count), 256'(2));

    // Five back-to-back beats with downstream stalled for three cycles.
    ir_base = ir_low_seen;
    fork
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 5; i++) send_beat(7'(i + 10), 1'b1, 7'(i + 20), 1'b1);
        idle();
      end
    join
    drain();
    chk("stall_in_ready_dropped", 256'(ir_low_seen > ir_base), 256'(1));

    // Random traffic under random backpressure.
    fork
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 25; i++)
          send_beat(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                    7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
        idle();
      end
    join
    drain();

    // Saturation of the correctable counter.
    for (int i = 0; i < 20; i++) send_beat(7'd1, 1'b1, 7'd2, 1'b1);
    idle();
    drain();
    chk("sat_corr", 256'(corr_count), 256'(15));

    // Clear coinciding with a CORR output transfer leaves zero.
    out_ready = 1'b0;
    send_beat(7'd9, 1'b1, 7'd0, 1'b0);
    idle();
    @(posedge clk);
    #1;
    chk("clr_pending_valid", 256'(out_valid), 256'(1));
    cnt_clear = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cnt_clear = 1'b0;
    chk("clr_corr", 256'(corr_count), 256'(0));
    chk("clr_ue", 256'(ue_count), 256'(0));

    // Async reset with both stages full discards everything.
    send_beat(7'd4, 1'b1, 7'd0, 1'b0);
    idle();
    drain();
    out_ready = 1'b0;
    send_beat(7'd6, 1'b1, 7'd0, 1'b0);
    send_beat(7'd7, 1'b1, 7'd8, 1'b1);
    idle();
    chk("full_in_ready", 256'(in_ready), 256'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 256'(out_valid), 256'(0));
    chk("arst_out_mask", 256'(out_mask), 256'(0));
    chk("arst_corr", 256'(corr_count), 256'(0));
    chk("arst_ue", 256'(ue_count), 256'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("arst_in_ready", 256'(in_ready), 256'(1));
    chk("arst_valid_after", 256'(out_valid), 256'(0));
    @(posedge clk);
    #1;
    send_beat(7'd9, 1'b1, 7'd0, 1'b0);
    idle();
    drain();
    chk("post_rst_corr", 256'(corr_count), 256'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
